// File: rtl/lb_ram_slave.sv
// rtl/lb_ram_slave.sv - LB slave scratch RAM with write wait states and read pipeline latency
// Optional byte-lane strobes enabled by defining LB_RAM_WSTRB_EN.
module lb_ram_slave #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 64,
    parameter int WR_WAIT    = 0,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     lb_waddr,
    input  logic [DATA_W-1:0]     lb_wdata,
    input  logic                  lb_wen,
    input  logic [DATA_W/8-1:0]   lb_wstrb,
    output logic                  lb_wready,
    input  logic [ADDR_W-1:0]     lb_raddr,
    input  logic                  lb_ren,
    output logic [DATA_W-1:0]     lb_rdata,
    output logic                  lb_rvalid
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SPAN  = DEPTH * BYTES;

    localparam logic [1:0]    WR_LAST  = 2'((WR_WAIT > 0) ? WR_WAIT - 1 : 0);
    localparam logic [1:0]    RD_LAST  = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [ADDR_W:0] SPAN_EXT = (ADDR_W + 1)'(SPAN);

    if (WR_WAIT < 0 || WR_WAIT > 3) begin : g_bad_wr_wait
        $error("lb_ram_slave: WR_WAIT must be 0..3");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
        $error("lb_ram_slave: RD_LATENCY must be 1..4");
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("lb_ram_slave: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lb_ram_slave: DEPTH must be a power of 2");
    end
    if (SPAN > (2 ** ADDR_W)) begin : g_bad_span
        $error("lb_ram_slave: DEPTH*DATA_W/8 exceeds address space");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;
    logic             w_in_range;
    logic             r_in_range;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_out;
    logic             unused_bits;

    assign widx       = lb_waddr[IDX_W+OFF_W-1:OFF_W];
    assign ridx       = lb_raddr[IDX_W+OFF_W-1:OFF_W];
    assign w_in_range = {1'b0, lb_waddr} < SPAN_EXT;
    assign r_in_range = {1'b0, lb_raddr} < SPAN_EXT;
    assign rd_word    = r_in_range ? mem[ridx] : '0;
    assign unused_bits = ^{lb_waddr, lb_raddr, lb_wstrb};

    // Write channel
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_COMMIT} wstate_t;
    wstate_t    wstate, wstate_nxt;
    logic [1:0] wcnt, wcnt_nxt;
    logic       wr_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate <= W_IDLE;
            wcnt   <= 2'd0;
        end else begin
            wstate <= wstate_nxt;
            wcnt   <= wcnt_nxt;
        end
    end

    // COMMIT is the wready cycle; the RAM is written on the edge that enters it
    always_comb begin
        wstate_nxt = wstate;
        wcnt_nxt   = wcnt;
        wr_commit  = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (lb_wen) begin
                    if (WR_WAIT == 0) begin
                        wr_commit  = 1'b1;
                        wstate_nxt = W_COMMIT;
                    end else begin
                        wstate_nxt = W_WAIT;
                        wcnt_nxt   = 2'd0;
                    end
                end
            end
            W_WAIT: begin
                if (wcnt == WR_LAST) begin
                    wr_commit  = 1'b1;
                    wstate_nxt = W_COMMIT;
                    wcnt_nxt   = 2'd0;
                end else begin
                    wcnt_nxt = wcnt + 2'd1;
                end
            end
            W_COMMIT: wstate_nxt = W_IDLE;
            default:  wstate_nxt = W_IDLE;
        endcase
    end

    assign lb_wready = (wstate == W_COMMIT);

    // RAM is not reset; rst_n gate keeps a request held through reset from landing
    always_ff @(posedge clk) begin
        if (rst_n && wr_commit && w_in_range) begin
`ifdef LB_RAM_WSTRB_EN
            for (int i = 0; i < BYTES; i++) begin
                if (lb_wstrb[i]) begin
                    mem[widx][8*i +: 8] <= lb_wdata[8*i +: 8];
                end
            end
`else
            mem[widx] <= lb_wdata;
`endif
        end
    end

    // Read channel
    typedef enum logic {R_IDLE, R_BUSY} rstate_t;
    rstate_t    rstate, rstate_nxt;
    logic [1:0] rcnt, rcnt_nxt;
    logic       rd_accept;
    logic       rd_deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= R_IDLE;
            rcnt   <= 2'd0;
        end else begin
            rstate <= rstate_nxt;
            rcnt   <= rcnt_nxt;
        end
    end

    // BUSY spans acceptance through the rvalid cycle, so a held lb_ren is not re-accepted
    always_comb begin
        rstate_nxt = rstate;
        rcnt_nxt   = rcnt;
        rd_accept  = 1'b0;
        rd_deliver = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (lb_ren) begin
                    rd_accept  = 1'b1;
                    rstate_nxt = R_BUSY;
                    rcnt_nxt   = 2'd0;
                    if (RD_LATENCY == 1) begin
                        rd_deliver = 1'b1;
                    end
                end
            end
            R_BUSY: begin
                if (lb_rvalid) begin
                    rstate_nxt = R_IDLE;
                end else if (rcnt == RD_LAST) begin
                    rd_deliver = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + 2'd1;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    if (RD_LATENCY == 1) begin : g_no_pipe
        assign rd_out = rd_word;
    end else begin : g_pipe
        logic [DATA_W-1:0] pipe [RD_LATENCY-1];

        always_ff @(posedge clk) begin
            if (rd_accept) begin
                pipe[0] <= rd_word;
            end
            for (int i = 1; i < RD_LATENCY - 1; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end

        assign rd_out = pipe[RD_LATENCY-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_rvalid <= 1'b0;
            lb_rdata  <= '0;
        end else begin
            lb_rvalid <= rd_deliver;
            if (rd_deliver) begin
                lb_rdata <= rd_out;
            end
        end
    end

endmodule
